fifo_reader: RTL

- Read-side engine for the dpram-backed `fifo`. It drives the FIFO's read strobe, absorbs the dpram read latency, and presents words as a valid/ready stream.
- Transfers run as bursts of a requested length. Each burst is framed with `busy`/`done`/`out_LAST`.
- Sits between the FIFO's read port and downstream consumers (packetizers, DMA). The FIFO's write side is untouched.

---
 rtl/fifo_reader.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/fifo_reader.sv
// fifo_reader: read-side burst engine for the dpram-backed fifo; hides the read latency and presents a valid/ready stream.
// Optional idle timeout on an empty FIFO is enabled by defining FIFO_READER_TIMEOUT_EN.
module fifo_reader #(
    parameter int unsigned DATA    = 16,
    parameter int unsigned ADDR    = 5,
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned LEN_W   = 8
`ifdef FIFO_READER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 64
`endif
) (
    input  logic             clK,
    input  logic             rsT,
    output logic             fifo_RD,
    input  logic [DATA-1:0]  fifo_OUT,
    input  logic [ADDR-1:0]  fifo_COUNT,
    input  logic             start,
    input  logic [LEN_W-1:0] burst_LEN,
    output logic             busy,
    output logic             done,
    output logic             out_VALID,
    output logic [DATA-1:0]  out_DATA,
    output logic             out_LAST,
    input  logic             out_READY
`ifdef FIFO_READER_TIMEOUT_EN
    ,
    output logic             err_TIMEOUT
`endif
);

    localparam int unsigned BUF_DEPTH = RD_LAT + 2;
    localparam int unsigned OCC_W     = $clog2(BUF_DEPTH + 1);
    localparam int unsigned CNT_W     = OCC_W + 2;
    localparam int unsigned PIPE_W    = (RD_LAT == 0) ? 1 : RD_LAT;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   remain_q, remain_d;
    logic [LEN_W-1:0]   deliver_q, deliver_d;
    logic [PIPE_W-1:0]  pipe_q;
    logic               cap;
    logic [DATA-1:0]    buf_q [BUF_DEPTH];
    logic [DATA-1:0]    buf_d [BUF_DEPTH];
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [OCC_W-1:0]   wr_idx;
    logic               pop;
    logic               avail;
    logic               credit;
    logic               rd_d;

`ifdef FIFO_READER_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic               err_d;
`endif

    assign pop      = out_VALID & out_READY;
    assign out_DATA = buf_q[0];

    // Subtract the strobe the occupancy input has not yet seen.
    assign avail = fifo_COUNT > ADDR'(fifo_RD);

    // Credit counts buffered words after this cycle's pop plus every read still travelling.
    assign credit = (CNT_W'(occ_q) + CNT_W'(fifo_RD) + CNT_W'($countones(pipe_q)) - CNT_W'(pop))
                    < CNT_W'(BUF_DEPTH);

    // Latency pipe: tags which cycles carry a word on fifo_OUT.
    generate
        if (RD_LAT == 0) begin : g_lat0
            assign pipe_q = '0;
            assign cap    = fifo_RD;
        end else begin : g_latn
            always_ff @(posedge clK or negedge rsT) begin
                if (!rsT) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q[0] <= fifo_RD;
                    for (int i = 1; i < int'(PIPE_W); i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end
            assign cap = pipe_q[PIPE_W-1];
        end
    endgenerate

    // Output buffer: entry 0 is the head and drives out_DATA directly.
    always_comb begin
        buf_d  = buf_q;
        wr_idx = occ_q - OCC_W'(pop);
        if (pop) begin
            for (int i = 0; i < int'(BUF_DEPTH) - 1; i++) begin
                buf_d[i] = buf_q[i+1];
            end
        end
        if (cap) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                if (OCC_W'(i) == wr_idx) begin
                    buf_d[i] = fifo_OUT;
                end
            end
        end
        occ_d = occ_q + OCC_W'(cap) - OCC_W'(pop);
    end

    // Burst control: next state, counters and read strobe.
    always_comb begin
        state_d   = state_q;
        remain_d  = remain_q;
        deliver_d = deliver_q;
        rd_d      = 1'b0;
`ifdef FIFO_READER_TIMEOUT_EN
        idle_d    = (state_q == ST_RUN && !fifo_RD) ? idle_q : '0;
        err_d     = 1'b0;
`endif
        if (pop && deliver_q != '0) begin
            deliver_d = deliver_q - LEN_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (burst_LEN != '0) begin
                        remain_d  = burst_LEN;
                        deliver_d = burst_LEN;
                        state_d   = ST_RUN;
                    end else begin
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (remain_q != '0 && avail && credit) begin
                    rd_d     = 1'b1;
                    remain_d = remain_q - LEN_W'(1);
                    if (remain_q == LEN_W'(1)) begin
                        state_d = ST_FLUSH;
                    end
                end
`ifdef FIFO_READER_TIMEOUT_EN
                else if (!avail && !fifo_RD) begin
                    if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                        // Abandon unissued words so out_LAST lands on the last issued one.
                        deliver_d = deliver_d - remain_q;
                        remain_d  = '0;
                        idle_d    = '0;
                        err_d     = 1'b1;
                        state_d   = ST_FLUSH;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
`endif
            end
            ST_FLUSH: begin
                if (deliver_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clK or negedge rsT) begin
        if (!rsT) begin
            state_q   <= ST_IDLE;
            remain_q  <= '0;
            deliver_q <= '0;
            occ_q     <= '0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                buf_q[i] <= '0;
            end
            fifo_RD   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_VALID <= 1'b0;
            out_LAST  <= 1'b0;
        end else begin
            state_q   <= state_d;
            remain_q  <= remain_d;
            deliver_q <= deliver_d;
            occ_q     <= occ_d;
            buf_q     <= buf_d;
            fifo_RD   <= rd_d;
            busy      <= (state_d == ST_RUN) || (state_d == ST_FLUSH);
            done      <= (state_d == ST_DONE);
            out_VALID <= (occ_d != '0);
            out_LAST  <= (occ_d != '0) && (deliver_d == LEN_W'(1));
        end
    end

`ifdef FIFO_READER_TIMEOUT_EN
    always_ff @(posedge clK or negedge rsT) begin
        if (!rsT) begin
            idle_q      <= '0;
            err_TIMEOUT <= 1'b0;
        end else begin
            idle_q      <= idle_d;
            err_TIMEOUT <= err_d;
        end
    end
`endif

endmodule
